// File: rtl/mode_ctrl_pkg.sv
// Shared definitions for the mode-control protocol: reserved characters, rate codes,
// encoder states and byte-classification helpers used by both link ends.
package mode_ctrl_pkg;

    localparam logic [7:0] CH_M   = 8'h4D;
    localparam logic [7:0] CH_m   = 8'h6D;
    localparam logic [7:0] CH_F   = 8'h46;
    localparam logic [7:0] CH_f   = 8'h66;
    localparam logic [7:0] CH_NUL = 8'h00;
    localparam logic [7:0] CH_R1  = 8'h31;
    localparam logic [7:0] CH_R5  = 8'h35;
    localparam logic [7:0] CH_RA  = 8'h41;

    typedef enum logic [1:0] {
        RATE_1   = 2'b00,
        RATE_5   = 2'b01,
        RATE_A   = 2'b10,
        RATE_BAD = 2'b11
    } rate_t;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_SEND_M    = 3'd1,
        ST_SEND_RATE = 3'd2,
        ST_SEND_F    = 3'd3,
        ST_SEND_DATA = 3'd4,
        ST_GAP       = 3'd5
    } state_t;

    // Bytes the far-end decoder treats as framing; never allowed as payload.
    function automatic logic is_reserved(input logic [7:0] b);
        return (b == CH_NUL) || (b == CH_M) || (b == CH_m) || (b == CH_F) || (b == CH_f);
    endfunction

    function automatic logic [7:0] rate_char(input rate_t r);
        case (r)
            RATE_1:  return CH_R1;
            RATE_5:  return CH_R5;
            RATE_A:  return CH_RA;
            default: return CH_NUL;
        endcase
    endfunction

    // Byte driven in a command SEND state; payload bytes are latched separately.
    function automatic logic [7:0] send_byte(input state_t st, input rate_t r);
        case (st)
            ST_SEND_M:    return CH_M;
            ST_SEND_RATE: return rate_char(r);
            ST_SEND_F:    return CH_F;
            default:      return CH_NUL;
        endcase
    endfunction

endpackage

// File: rtl/mode_command_tx_if.sv
// Handshake bundle between the host, the mode-command encoder and the UART transmitter.
interface mode_command_tx_if;

    logic       icmd_valid;
    logic [1:0] icmd_rate;
    logic       ocmd_ready;
    logic [7:0] idata;
    logic       idata_valid;
    logic       odata_ready;
    logic [7:0] otx_data;
    logic       otx_valid;
    logic       itx_ready;

    // Encoder side.
    modport master (
        input  icmd_valid, icmd_rate, idata, idata_valid, itx_ready,
        output ocmd_ready, odata_ready, otx_data, otx_valid
    );

    // Host / UART side.
    modport slave (
        output icmd_valid, icmd_rate, idata, idata_valid, itx_ready,
        input  ocmd_ready, odata_ready, otx_data, otx_valid
    );

endinterface

// File: rtl/mode_tx_gap_timer.sv
// Inter-byte idle timer: loaded with GAP_CYCLES on a byte handoff, counts down while
// the encoder sits in its gap state, and flags the last gap cycle.
module mode_tx_gap_timer #(
    parameter int GAP_CYCLES = 4,
    parameter int GAP_W      = 8
) (
    input  logic clk,
    input  logic reset,
    input  logic load,
    input  logic dec,
    output logic done
);

    localparam logic [GAP_W-1:0] LOAD_VAL = GAP_W'(GAP_CYCLES);
    localparam logic [GAP_W-1:0] ONE      = GAP_W'(1);
    localparam logic [GAP_W-1:0] ZERO     = GAP_W'(0);

    logic [GAP_W-1:0] cnt_r;

    // Gap counter: load wins over decrement; never wraps below zero.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt_r <= ZERO;
        end else if (load) begin
            cnt_r <= LOAD_VAL;
        end else if (dec && (cnt_r != ZERO)) begin
            cnt_r <= cnt_r - ONE;
        end
    end

    assign done = (cnt_r == ONE);

endmodule

// File: rtl/mode_command_tx.sv
// Host-side mode-control encoder: expands rate commands into 'M',<rate>,'F', forwards
// non-reserved payload bytes, and paces every byte to the UART with an idle gap.
module mode_command_tx
    import mode_ctrl_pkg::*;
#(
    parameter int GAP_CYCLES = 4,
    parameter int GAP_W      = 8
) (
    input  logic               clk,
    input  logic               reset,
    mode_command_tx_if.master  bus,
    output logic               obusy,
    output logic               oerr,
    output logic [1:0]         orate_sent
);

    state_t     state_r;
    state_t     gap_next_r;
    state_t     after_s;
    rate_t      rate_r;
    rate_t      orate_sent_r;
    rate_t      cmd_rate_s;
    logic [7:0] otx_data_r;
    logic       otx_valid_r;
    logic       oerr_r;
    logic       idle_s;
    logic       cmd_fire_s;
    logic       data_fire_s;
    logic       handoff_s;
    logic       gap_load_s;
    logic       gap_dec_s;
    logic       gap_done_s;

    assign idle_s      = (state_r == ST_IDLE);
    assign cmd_rate_s  = rate_t'(bus.icmd_rate);
    // Commands take priority: a payload byte is only offered when no command is pending.
    assign cmd_fire_s  = idle_s & bus.icmd_valid;
    assign data_fire_s = idle_s & ~bus.icmd_valid & bus.idata_valid;
    assign handoff_s   = otx_valid_r & bus.itx_ready;
    assign gap_load_s  = handoff_s & (GAP_CYCLES != 0);
    assign gap_dec_s   = (state_r == ST_GAP);

    assign bus.ocmd_ready  = idle_s;
    assign bus.odata_ready = idle_s & ~bus.icmd_valid;
    assign bus.otx_data    = otx_data_r;
    assign bus.otx_valid   = otx_valid_r;
    assign obusy           = ~idle_s;
    assign oerr            = oerr_r;
    assign orate_sent      = orate_sent_r;

    mode_tx_gap_timer #(
        .GAP_CYCLES (GAP_CYCLES),
        .GAP_W      (GAP_W)
    ) u_gap_timer (
        .clk   (clk),
        .reset (reset),
        .load  (gap_load_s),
        .dec   (gap_dec_s),
        .done  (gap_done_s)
    );

    // State that follows the byte currently on the wire once its gap has elapsed.
    always_comb begin
        after_s = ST_IDLE;
        case (state_r)
            ST_SEND_M:    after_s = ST_SEND_RATE;
            ST_SEND_RATE: after_s = ST_SEND_F;
            default:      after_s = ST_IDLE;
        endcase
    end

    // Encoder FSM with registered byte, valid, error and last-rate outputs.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r      <= ST_IDLE;
            gap_next_r   <= ST_IDLE;
            rate_r       <= RATE_1;
            orate_sent_r <= RATE_1;
            otx_data_r   <= 8'h00;
            otx_valid_r  <= 1'b0;
            oerr_r       <= 1'b0;
        end else begin
            oerr_r <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    if (cmd_fire_s) begin
                        if (cmd_rate_s == RATE_BAD) begin
                            oerr_r <= 1'b1;
                        end else begin
                            rate_r      <= cmd_rate_s;
                            state_r     <= ST_SEND_M;
                            otx_data_r  <= CH_M;
                            otx_valid_r <= 1'b1;
                        end
                    end else if (data_fire_s) begin
                        // Reserved bytes are swallowed so the decoder never sees a stray frame.
                        if (is_reserved(bus.idata)) begin
                            oerr_r <= 1'b1;
                        end else begin
                            state_r     <= ST_SEND_DATA;
                            otx_data_r  <= bus.idata;
                            otx_valid_r <= 1'b1;
                        end
                    end
                end
                ST_SEND_M, ST_SEND_RATE, ST_SEND_F, ST_SEND_DATA: begin
                    if (handoff_s) begin
                        if (state_r == ST_SEND_F) begin
                            orate_sent_r <= rate_r;
                        end
                        if (GAP_CYCLES == 0) begin
                            state_r     <= after_s;
                            otx_valid_r <= (after_s != ST_IDLE);
                            otx_data_r  <= send_byte(after_s, rate_r);
                        end else begin
                            state_r     <= ST_GAP;
                            otx_valid_r <= 1'b0;
                            gap_next_r  <= after_s;
                        end
                    end
                end
                ST_GAP: begin
                    if (gap_done_s) begin
                        state_r <= gap_next_r;
                        if (gap_next_r != ST_IDLE) begin
                            otx_valid_r <= 1'b1;
                            otx_data_r  <= send_byte(gap_next_r, rate_r);
                        end
                    end
                end
                default: begin
                    state_r     <= ST_IDLE;
                    otx_valid_r <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mode_command_tx.sv
// Self-checking bench for mode_command_tx: directed protocol scenarios followed by random
// traffic, all compared cycle by cycle against a queue-based byte-stream model.
module tb_mode_command_tx;

    localparam int G = 4;

    logic       clk = 1'b0;
    logic       reset;
    logic       obusy;
    logic       oerr;
    logic [1:0] orate_sent;

    always #5 clk = ~clk;

    mode_command_tx_if bus_if ();

    mode_command_tx #(
        .GAP_CYCLES (G),
        .GAP_W      (8)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .bus        (bus_if),
        .obusy      (obusy),
        .oerr       (oerr),
        .orate_sent (orate_sent)
    );

    typedef struct {
        logic [7:0] b;
        bit         upd;
        logic [1:0] r;
    } ent_t;

    // Model: bytes still owed to the UART, remaining idle cycles, whether the head is on the wire.
    ent_t       q[$];
    int         gap_left;
    bit         presenting;
    logic [1:0] m_rate;
    bit         m_err;
    logic [7:0] rate_chr [3] = '{8'h31, 8'h35, 8'h41};
    logic [7:0] res_chr  [5] = '{8'h00, 8'h4D, 8'h6D, 8'h46, 8'h66};

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s @%0t: got %0h expected %0h", tag, $time, got, exp);
        end
    endtask

    task automatic model_clear();
        q.delete();
        gap_left   = 0;
        presenting = 1'b0;
        m_rate     = 2'b00;
        m_err      = 1'b0;
    endtask

    function automatic bit reserved(input logic [7:0] b);
        return b inside {8'h00, 8'h4D, 8'h6D, 8'h46, 8'h66};
    endfunction

    task automatic push_byte(input logic [7:0] b, input bit upd, input logic [1:0] r);
        ent_t e;
        e.b   = b;
        e.upd = upd;
        e.r   = r;
        q.push_back(e);
    endtask

    task automatic compare_all();
        bit idle_e;
        idle_e = !presenting && (gap_left == 0);
        check_eq("otx_valid", {31'd0, bus_if.otx_valid}, {31'd0, presenting});
        if (presenting) check_eq("otx_data", {24'd0, bus_if.otx_data}, {24'd0, q[0].b});
        check_eq("ocmd_ready", {31'd0, bus_if.ocmd_ready}, {31'd0, idle_e});
        check_eq("odata_ready", {31'd0, bus_if.odata_ready}, {31'd0, idle_e & !bus_if.icmd_valid});
        check_eq("obusy", {31'd0, obusy}, {31'd0, !idle_e});
        check_eq("oerr", {31'd0, oerr}, {31'd0, m_err});
        check_eq("orate_sent", {30'd0, orate_sent}, {30'd0, m_rate});
    endtask

    // Advance the model across the coming rising edge given the inputs about to be sampled.
    task automatic model_edge(input bit cv, input logic [1:0] rate, input bit dv,
                              input logic [7:0] d, input bit txr);
        ent_t e;
        m_err = 1'b0;
        if (presenting) begin
            if (txr) begin
                e = q.pop_front();
                if (e.upd) m_rate = e.r;
                presenting = 1'b0;
                gap_left   = G;
                if (G == 0 && q.size() != 0) presenting = 1'b1;
            end
        end else if (gap_left > 0) begin
            gap_left--;
            if (gap_left == 0 && q.size() != 0) presenting = 1'b1;
        end else if (cv) begin
            if (rate == 2'b11) begin
                m_err = 1'b1;
            end else begin
                push_byte(8'h4D, 1'b0, rate);
                push_byte(rate_chr[rate], 1'b0, rate);
                push_byte(8'h46, 1'b1, rate);
                presenting = 1'b1;
            end
        end else if (dv) begin
            if (reserved(d)) begin
                m_err = 1'b1;
            end else begin
                push_byte(d, 1'b0, 2'b00);
                presenting = 1'b1;
            end
        end
    endtask

    task automatic step(input bit cv, input logic [1:0] rate, input bit dv,
                        input logic [7:0] d, input bit txr);
        @(negedge clk);
        compare_all();
        bus_if.icmd_valid  = cv;
        bus_if.icmd_rate   = rate;
        bus_if.idata_valid = dv;
        bus_if.idata       = d;
        bus_if.itx_ready   = txr;
        model_edge(cv, rate, dv, d, txr);
    endtask

    task automatic idle_steps(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 2'b00, 1'b0, 8'h00, 1'b1);
    endtask

    task automatic drive_zero();
        bus_if.icmd_valid  = 1'b0;
        bus_if.icmd_rate   = 2'b00;
        bus_if.idata_valid = 1'b0;
        bus_if.idata       = 8'h00;
        bus_if.itx_ready   = 1'b0;
    endtask

    // Asynchronous reset in the middle of a cycle; outputs must drop without a clock edge.
    task automatic apply_reset();
        @(negedge clk);
        compare_all();
        #2;
        reset = 1'b0;
        drive_zero();
        #1;
        check_eq("rst_otx_valid", {31'd0, bus_if.otx_valid}, 32'd0);
        check_eq("rst_obusy", {31'd0, obusy}, 32'd0);
        check_eq("rst_ocmd_ready", {31'd0, bus_if.ocmd_ready}, 32'd1);
        model_clear();
        @(negedge clk);
        reset = 1'b1;
    endtask

    initial begin
        reset = 1'b0;
        drive_zero();
        model_clear();
        repeat (2) @(negedge clk);
        check_eq("reset_otx_data", {24'd0, bus_if.otx_data}, 32'h00);
        check_eq("reset_otx_valid", {31'd0, bus_if.otx_valid}, 32'd0);
        check_eq("reset_obusy", {31'd0, obusy}, 32'd0);
        check_eq("reset_oerr", {31'd0, oerr}, 32'd0);
        check_eq("reset_orate", {30'd0, orate_sent}, 32'd0);
        check_eq("reset_ocmd_ready", {31'd0, bus_if.ocmd_ready}, 32'd1);
        check_eq("reset_odata_ready", {31'd0, bus_if.odata_ready}, 32'd1);
        reset = 1'b1;

        // Rate 'A' command with the UART always ready.
        step(1'b1, 2'b10, 1'b0, 8'h00, 1'b1);
        idle_steps(20);
        check_eq("t1_orate_sent", {30'd0, orate_sent}, 32'd2);

        // Payload 0x55 stalled by the UART for three cycles.
        step(1'b0, 2'b00, 1'b1, 8'h55, 1'b0);
        for (int i = 0; i < 3; i++) step(1'b0, 2'b00, 1'b0, 8'h00, 1'b0);
        idle_steps(8);

        // Reserved payload bytes 'm' then NUL.
        step(1'b0, 2'b00, 1'b1, 8'h6D, 1'b1);
        step(1'b0, 2'b00, 1'b1, 8'h00, 1'b1);
        idle_steps(3);

        // Command and payload together; the payload is held until taken.
        step(1'b1, 2'b01, 1'b1, 8'h5A, 1'b1);
        for (int i = 0; i < 16; i++) step(1'b0, 2'b00, 1'b1, 8'h5A, 1'b1);
        idle_steps(10);

        // Illegal rate code.
        step(1'b1, 2'b11, 1'b0, 8'h00, 1'b1);
        idle_steps(3);
        check_eq("t5_orate_sent", {30'd0, orate_sent}, 32'd1);

        // Reset while the rate character is stalled on the wire.
        step(1'b1, 2'b00, 1'b0, 8'h00, 1'b1);
        step(1'b0, 2'b00, 1'b0, 8'h00, 1'b1);
        for (int i = 0; i < G + 1; i++) step(1'b0, 2'b00, 1'b0, 8'h00, 1'b0);
        apply_reset();
        step(1'b1, 2'b01, 1'b0, 8'h00, 1'b1);
        idle_steps(20);

        // Random traffic.
        for (int i = 0; i < 4000; i++) begin
            logic [7:0] d;
            d = ($urandom_range(0, 3) == 0) ? res_chr[$urandom_range(0, 4)] : 8'($urandom);
            step(($urandom_range(0, 3) == 0), 2'($urandom), ($urandom_range(0, 2) == 0),
                 d, ($urandom_range(0, 3) != 0));
        end
        idle_steps(20);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
